// File: rtl/instruction_decoder.sv
// Purpose: instruction register plus decoder; drives datapath enables/selects and sequencer jump/NOP controls.
// Latency: ir captures pm_data each edge; controls are combinational from ir; z and instr_count update on the edge.
// Backpressure: none; one instruction executes every cycle reset is low.
module instruction_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [7:0]       pm_data,
  input  logic             alu_zero,
  output logic [7:0]       ir,
  output logic [7:0]       reg_en,
  output logic             r_en,
  output logic [2:0]       src_sel,
  output logic             imm_sel,
  output logic             x_sel,
  output logic             y_sel,
  output logic [2:0]       alu_func,
  output logic             jmp,
  output logic             jmp_nz,
  output logic [3:0]       jmp_addr,
  output logic             dont_jmp,
  output logic             NOPC8,
  output logic             NOPCF,
  output logic             NOPD8,
  output logic             NOPDF,
  output logic [CNT_W-1:0] instr_count
);

  logic [7:0]       ir_q, ir_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_ldi, is_mov, is_alu, is_jmp, is_jnz;
  logic nop_lo, nop_hi, is_nop;

  // Instruction class decode from the held word; reset gating is applied to the outputs below
  always_comb begin
    is_ldi = ~ir_q[7];
    is_mov = (ir_q[7:6] == 2'b10);
    is_alu = (ir_q[7:5] == 3'b110);
    is_jmp = (ir_q[7:4] == 4'b1110);
    is_jnz = (ir_q[7:4] == 4'b1111);
    // NOP words: ALU class with y_sel set and function 000 or 111
    nop_lo = is_alu & ir_q[3] & (ir_q[2:0] == 3'b000);
    nop_hi = is_alu & ir_q[3] & (ir_q[2:0] == 3'b111);
    is_nop = nop_lo | nop_hi;
  end

  // Control outputs: enables forced low during reset, selects always follow ir
  always_comb begin
    reg_en   = 8'h00;
    r_en     = 1'b0;
    imm_sel  = 1'b0;
    jmp      = 1'b0;
    jmp_nz   = 1'b0;
    NOPC8    = 1'b0;
    NOPCF    = 1'b0;
    NOPD8    = 1'b0;
    NOPDF    = 1'b0;
    src_sel  = ir_q[2:0];
    x_sel    = ir_q[4];
    y_sel    = ir_q[3];
    alu_func = ir_q[2:0];
    jmp_addr = ir_q[3:0];
    if (!sync_reset) begin
      if (is_ldi) begin
        reg_en  = 8'h01 << ir_q[6:4];
        imm_sel = 1'b1;
      end
      if (is_mov) begin
        // dst == src is still a legal move and is executed
        reg_en = 8'h01 << ir_q[5:3];
      end
      r_en   = is_alu & ~is_nop;
      jmp    = is_jmp;
      jmp_nz = is_jnz;
      NOPC8  = nop_lo & ~ir_q[4];
      NOPCF  = nop_hi & ~ir_q[4];
      NOPD8  = nop_lo &  ir_q[4];
      NOPDF  = nop_hi &  ir_q[4];
    end
  end

  // Next-state: ir tracks program memory, z samples only real ALU ops, counter saturates
  always_comb begin
    ir_d  = pm_data;
    z_d   = z_q;
    cnt_d = cnt_q;
    if (is_alu && !is_nop) begin
      z_d = alu_zero;
    end
    if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State update; ir loads even in reset so word 0 is ready when reset drops
  always_ff @(posedge clk) begin
    ir_q <= ir_d;
    if (sync_reset) begin
      z_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      z_q   <= z_d;
      cnt_q <= cnt_d;
    end
  end

  assign ir          = ir_q;
  assign dont_jmp    = z_q;
  assign instr_count = cnt_q;

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
- Stage directly downstream of the program sequencer: captures the program-memory word into the instruction register (ir) and decodes it.
- Drives datapath load enables, source/ALU selects and the sequencer's control inputs: jmp, jmp_nz, jmp_addr, dont_jmp, NOPC8/NOPCF/NOPD8/NOPDF.
- Owns the zero flag used for conditional jumps and a saturating executed-instruction counter.

Parameters:
- CNT_W, 16, width of executed-instruction counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- sync_reset  in  1  synchronous, active-high reset
- pm_data  in  8  program memory word at current pm_addr
- alu_zero  in  1  combinational "ALU result == 0" from the ALU for the current ir
- ir  out  8  instruction register
- reg_en  out  8  one-hot load enables: [0]x0 [1]x1 [2]y0 [3]y1 [4]o_reg [5]m [6]i [7]dm
- r_en  out  1  ALU result register load enable
- src_sel  out  3  data-bus source: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 i_pins
- imm_sel  out  1  data bus takes ir[3:0] (zero-extended)
- x_sel, y_sel  out  1 each  ALU operand selects
- alu_func  out  3  ALU function code
- jmp, jmp_nz  out  1 each  to sequencer
- jmp_addr  out  4  to sequencer
- dont_jmp  out  1  registered zero flag z, to sequencer
- NOPC8, NOPCF, NOPD8, NOPDF  out  1 each  NOP detects, to sequencer
- instr_count  out  CNT_W  executed (non-reset) instruction count

Behaviour:
- ir <= pm_data on every rising edge, including while sync_reset=1, so the word at address 0 is in ir when reset drops. ir has no reset value of its own.
- Encoding (decided):
  - Load immediate: ir[7]=0. dst=ir[6:4], imm_sel=1, data=ir[3:0].
  - Move: ir[7:6]=10. dst=ir[5:3], src_sel=ir[2:0]. When dst==src, the move still executes.
  - ALU: ir[7:5]=110. x_sel=ir[4], y_sel=ir[3], alu_func=ir[2:0], r_en=1.
    - NOP when ir[3]=1 and ir[2:0] is 000 or 111, i.e. 0xC8, 0xCF, 0xD8, 0xDF.
    - On a NOP, r_en=0 and exactly one matching NOPxx output is 1.
  - Jump: ir[7:4]=1110 → jmp=1; ir[7:4]=1111 → jmp_nz=1. jmp_addr=ir[3:0] always.
- Dst code maps to the reg_en bit of the same index. At most one reg_en bit is high; a jump or ALU instruction drives no reg_en bit.
- All control outputs (reg_en, r_en, imm_sel, jmp, jmp_nz, NOPxx) are combinational from ir.
- While sync_reset=1, all control outputs are forced to 0. Selects and jmp_addr are don't-care but follow ir.
- Zero flag z (dont_jmp):
  - Reset to 0.
  - On a clock edge where an executing non-NOP ALU instruction is in ir, z <= alu_zero.
  - Otherwise z holds, including across NOPs, loads, moves and jumps.
  - jmp_nz is not gated here; the sequencer combines it with dont_jmp.
- instr_count:
  - Reset to 0.
  - Increments by 1 on each edge with sync_reset=0, including NOPs and jumps.
  - Saturates at all-ones, no wrap.
  - A NOPC8-induced repeat counts each execution.
- Reset mid-operation: z and instr_count clear on the reset edge. Outputs are inactive for every cycle reset is high. Execution resumes from the ir captured at the last reset edge.

Test Plan:
- Reset held 2 cycles with pm_data=8'h0A, then released → all enables 0 during reset; first cycle after release, ir=8'h0A, reg_en=8'h01, imm_sel=1; instr_count=0, and 1 after next edge.
- Drive 8'h8C (move dst=1 src=4) → reg_en=8'h02, src_sel=4, imm_sel=0, r_en=0; z unchanged.
- ALU 8'hD2 with alu_zero=1, then 8'hF5 → r_en=1, x_sel=1, y_sel=0, alu_func=2; next cycle dont_jmp=1, jmp_nz=1, jmp_addr=5.
- Sweep 8'hC8, 8'hCF, 8'hD8, 8'hDF with alu_zero toggling → one NOPxx high per word, r_en=0, reg_en=0, z unchanged; 8'hC9 decodes as ALU with no NOP flag.
- 8'hE3 → jmp=1, jmp_addr=3, jmp_nz=0, no enables; 8'h70 → reg_en=8'h80 (dm write).
- Force instr_count to 2^CNT_W−2 via long run (CNT_W=4 override) → counts 14, 15, 15; assert reset mid-run → 0 next edge.
